// File: rtl/fusion_mac_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fusion_mac_ctrl
// Brief   : Job sequencer for a fusion MAC array: latches precision/sign mode,
//           meters operand beats and presents the accumulated result.
// Revision: 1.0 - initial release
// ============================================================================
module fusion_mac_ctrl #(
    parameter int CNT_WIDTH  = 16,
    parameter int PIPE_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [1:0]           cfg_mode,
    input  logic [1:0]           cfg_sign_mode,
    input  logic [CNT_WIDTH-1:0] cfg_len,
    output logic [1:0]           mode,
    output logic [1:0]           sign_mode,
    input  logic                 src_valid,
    output logic                 src_ready,
    output logic                 acc_clear,
    output logic                 acc_en,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 busy
);

    localparam int                   c_DRAIN_W    = 4;
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LOAD = c_DRAIN_W'(PIPE_DEPTH - 1);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ZERO   = '0;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE    = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_armed;
    logic [CNT_WIDTH-1:0]   r_beat_cnt;
    logic [c_DRAIN_W-1:0]   r_drain_cnt;
    logic [1:0]             r_mode;
    logic [1:0]             r_sign_mode;

    logic w_accept;
    logic w_beat;
    logic w_res_valid;
    logic w_res_hs;

    // r_armed keeps cfg_ready low while reset is held and for no longer.
    assign cfg_ready   = (r_state == S_IDLE) && r_armed;
    assign src_ready   = (r_state == S_RUN);
    assign w_accept    = cfg_valid && cfg_ready;
    assign w_beat      = src_valid && src_ready;

    // The last drain cycle already presents the result so that res_valid
    // rises exactly PIPE_DEPTH cycles after the final beat.
    assign w_res_valid = (r_state == S_HOLD) ||
                         ((r_state == S_DRAIN) && (r_drain_cnt == c_DRAIN_ZERO));
    assign w_res_hs    = w_res_valid && res_ready;

    assign acc_clear   = w_accept;
    assign acc_en      = w_beat;
    assign res_valid   = w_res_valid;
    assign busy        = (r_state != S_IDLE);
    assign mode        = r_mode;
    assign sign_mode   = r_sign_mode;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_armed     <= 1'b0;
            r_beat_cnt  <= c_CNT_ZERO;
            r_drain_cnt <= c_DRAIN_ZERO;
            r_mode      <= 2'd0;
            r_sign_mode <= 2'd0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mode      <= cfg_mode;
                        r_sign_mode <= cfg_sign_mode;
                        r_beat_cnt  <= cfg_len;
                        r_drain_cnt <= c_DRAIN_LOAD;
                        r_state     <= (cfg_len != c_CNT_ZERO) ? S_RUN : S_DRAIN;
                    end
                end
                S_RUN: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt - c_CNT_ONE;
                        if (r_beat_cnt == c_CNT_ONE) begin
                            r_drain_cnt <= c_DRAIN_LOAD;
                            r_state     <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_res_hs) begin
                        r_state <= S_IDLE;
                    end else if (r_drain_cnt == c_DRAIN_ZERO) begin
                        r_state <= S_HOLD;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_res_hs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
